// File: rtl/cl_vled_tx.sv
`default_nettype none
// ============================================================================
//  Module   : cl_vled_tx
//  Purpose  : Byte-stream transmitter to the host over the virtual LED pins.
//             Bytes are queued in a small FIFO and sent one at a time with a
//             4-phase REQ/ACK handshake. The host acknowledges on vdip[15].
//  Revision : 1.0 - initial release
// ============================================================================
module cl_vled_tx #(
  parameter int          FIFO_DEPTH  = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic                          clk_main_a0,
  input  logic                          rst_main_n,
  input  logic                          in_wr,
  input  logic [7:0]                    in_data,
  input  logic                          in_last,
  input  logic [15:0]                   sh_cl_status_vdip,
  output logic [15:0]                   cl_sh_status_vled,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int              c_AW    = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_REQ_HI   = 2'd1;
  localparam logic [1:0] c_ACK_WAIT = 2'd2;

  // vdip[13:1] carry nothing for this block; they are deliberately left unsampled.
  logic [12:0] w_unused_vdip;
  assign w_unused_vdip = sh_cl_status_vdip[13:1];

  // ---------------------------------------------------------------------------
  // Reset synchronizer: assertion is immediate, release takes two clocks.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       w_rst_n;

  // Two-flop reset release chain.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign w_rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Host control synchronizers (ACK, CLR_FLAGS, EN).
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ack_sync_q, clr_sync_q, en_sync_q;
  logic                   clr_prev_q;
  logic                   w_ack_s, w_clr_s, w_en_s, w_clr_rise;

  // Shift each host control bit through its own synchronizer chain.
  always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      ack_sync_q <= '0;
      clr_sync_q <= '0;
      en_sync_q  <= '0;
      clr_prev_q <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], sh_cl_status_vdip[15]};
      clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], sh_cl_status_vdip[14]};
      en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0],  sh_cl_status_vdip[0]};
      clr_prev_q <= w_clr_s;
    end
  end

  assign w_ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign w_clr_s    = clr_sync_q[SYNC_STAGES-1];
  assign w_en_s     = en_sync_q[SYNC_STAGES-1];
  assign w_clr_rise = w_clr_s & ~clr_prev_q;

  // ---------------------------------------------------------------------------
  // Byte FIFO, 9 bits wide ({last, data}).
  // ---------------------------------------------------------------------------
  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [c_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_AW:0]   count_q, count_d;
  logic            w_full, w_empty, w_push, w_pop, w_ovf_set;
  logic [8:0]      w_head;

  assign w_full    = (count_q == c_DEPTH);
  assign w_empty   = (count_q == '0);
  assign w_head    = mem_q[rd_ptr_q];
  // A pop frees a slot in the same cycle, so a push onto a full FIFO is
  // still taken when the state machine is draining it.
  assign w_push    = in_wr & (~w_full | w_pop);
  assign w_ovf_set = in_wr & ~w_push;

  // Occupancy bookkeeping for simultaneous push/pop.
  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= {in_last, in_data};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake state machine and output payload.
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic        req_q, req_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic [2:0]  seq_q, seq_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_q, tmo_d, ovf_q, ovf_d, nempty_q;
  logic        w_tmo_set;

  assign w_pop = (state_q == c_IDLE) & w_en_s & ~w_empty;

  // Next-state logic: payload and REQ are loaded together on the pop.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    last_d    = last_q;
    seq_d     = seq_q;
    tmo_cnt_d = tmo_cnt_q;
    w_tmo_set = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (w_en_s && !w_empty) begin
          state_d          = c_REQ_HI;
          req_d            = 1'b1;
          {last_d, data_d} = w_head;
          tmo_cnt_d        = '0;
        end
      end
      c_REQ_HI: begin
        if (w_ack_s) begin
          state_d = c_ACK_WAIT;
          req_d   = 1'b0;
          seq_d   = seq_q + 3'd1;
        end else if ((TIMEOUT_CYC != 32'd0) && (tmo_cnt_q != TIMEOUT_CYC)) begin
          // Saturates at the limit so the flag fires only once per byte.
          tmo_cnt_d = tmo_cnt_q + 32'd1;
          w_tmo_set = ((tmo_cnt_q + 32'd1) == TIMEOUT_CYC);
        end
      end
      c_ACK_WAIT: begin
        if (!w_ack_s) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Sticky flags: a set event in the same cycle beats a clear request.
  always_comb begin
    tmo_d = w_tmo_set ? 1'b1 : (w_clr_rise ? 1'b0 : tmo_q);
    ovf_d = w_ovf_set ? 1'b1 : (w_clr_rise ? 1'b0 : ovf_q);
  end

  // State, payload, flag and status registers.
  always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q   <= c_IDLE;
      req_q     <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      seq_q     <= '0;
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
      ovf_q     <= 1'b0;
      nempty_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      data_q    <= data_d;
      last_q    <= last_d;
      seq_q     <= seq_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
      nempty_q  <= ~w_empty;
    end
  end

  assign cl_sh_status_vled = {req_q, ovf_q, nempty_q, tmo_q, seq_q, last_q, data_q};
  assign fifo_level        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cl_vled_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cl_vled_tx
//  Purpose  : Self-checking bench for cl_vled_tx with a host handshake model
//             and a queue-based model of the expected byte stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cl_vled_tx;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_wr, in_last;
  logic [7:0]  in_data;
  logic        en, clr, man_ack, host_en, host_ack, host_rst;
  logic [15:0] vdip, vled;
  logic [4:0]  level;

  always #5 clk = ~clk;

  assign vdip = {(host_en ? host_ack : man_ack), clr, 13'd0, en};

  cl_vled_tx #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(32'd100)
  ) dut (
    .clk_main_a0      (clk),
    .rst_main_n       (rst_n),
    .in_wr            (in_wr),
    .in_data          (in_data),
    .in_last          (in_last),
    .sh_cl_status_vdip(vdip),
    .cl_sh_status_vled(vled),
    .fifo_level       (level)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- expected-stream model ----------------
  typedef struct packed { logic l; logic [7:0] d; } byte_t;
  byte_t exp_q[$];
  int    tot;      // completed transfers since reset -> expected seq = tot mod 8

  // ---------------- host model ----------------
  int         ack_dly, drop_dly, h_st, h_cnt, rx_cnt, rx_rd;
  logic [8:0] cur_first;
  logic [7:0] rx_d [512];
  logic       rx_l [512];
  logic [2:0] rx_s [512];
  logic [8:0] rx_first [512];

  initial begin
    h_st = 0; h_cnt = 0; rx_cnt = 0; host_ack = 1'b0; cur_first = '0;
    forever begin
      @(negedge clk);
      if (host_rst) begin
        h_st = 0; h_cnt = 0; rx_cnt = 0; host_ack = 1'b0;
      end else if (host_en) begin
        case (h_st)
          0: if (vled[15]) begin cur_first = vled[8:0]; h_cnt = 0; h_st = 1; end
          1: begin
            h_cnt++;
            if (h_cnt >= ack_dly) begin
              host_ack = 1'b1;
              if (rx_cnt < 512) begin
                rx_d[rx_cnt] = vled[7:0]; rx_l[rx_cnt] = vled[8];
                rx_s[rx_cnt] = vled[11:9]; rx_first[rx_cnt] = cur_first;
                rx_cnt++;
              end
              h_st = 2;
            end
          end
          2: if (!vled[15]) begin h_cnt = 0; h_st = 3; end
          3: begin
            h_cnt++;
            if (h_cnt >= drop_dly) begin host_ack = 1'b0; h_st = 0; end
          end
          default: h_st = 0;
        endcase
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic push_one(input logic [7:0] d, input logic l, input logic accept);
    in_wr = 1'b1; in_data = d; in_last = l;
    if (accept) exp_q.push_back({l, d});
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic check_rx(input int n);
    int g = 0;
    while ((rx_cnt < rx_rd + n || h_st != 0 || vled[15]) && g < 4000) begin
      @(negedge clk); g++;
    end
    chk("rx_count", rx_cnt, rx_rd + n);
    for (int i = 0; i < n; i++) begin
      byte_t e;
      if (rx_rd >= rx_cnt || exp_q.size() == 0) break;
      e = exp_q.pop_front();
      chk("rx_data",   rx_d[rx_rd],     e.d);
      chk("rx_last",   rx_l[rx_rd],     e.l);
      chk("rx_seq",    rx_s[rx_rd],     tot % 8);
      chk("rx_stable", rx_first[rx_rd], {e.l, e.d});
      rx_rd++; tot++;
    end
    repeat (3) @(negedge clk);
    chk("seq_after",   vled[11:9], tot % 8);
    chk("req_idle",    vled[15],   0);
    chk("level_empty", level,      0);
    chk("nonempty_lo", vled[13],   0);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       last;
    logic [4:0] exp_level;
    logic       exp_ne;
    logic       exp_ovf;
  } vec_t;
  vec_t vt [21];

  // ---------------- main sequence ----------------
  initial begin
    int   g;
    logic any_req;
    logic [8:0] held;

    for (int i = 0; i < 21; i++) begin
      vt[i].wr        = (i < 19);
      vt[i].data      = 8'h40 + 8'(i);
      vt[i].last      = (i == 15);
      vt[i].exp_level = (i < 16) ? 5'(i + 1) : 5'd16;
      vt[i].exp_ne    = (i > 0);
      vt[i].exp_ovf   = (i >= 16);
    end

    rst_n = 1'b0; in_wr = 1'b0; in_data = '0; in_last = 1'b0;
    en = 1'b0; clr = 1'b0; man_ack = 1'b0; host_en = 1'b1; host_rst = 1'b1;
    ack_dly = 5; drop_dly = 5; rx_rd = 0; tot = 0;
    repeat (3) @(negedge clk);
    chk("reset_vled",  vled,  16'h0000);
    chk("reset_level", level, 0);
    rst_n = 1'b1; host_rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_reset_vled", vled, 16'h0000);

    // Overflow with EN=0: table of pushes, checked one cycle at a time.
    for (int i = 0; i < 21; i++) begin
      in_wr = vt[i].wr; in_data = vt[i].data; in_last = vt[i].last;
      if (vt[i].wr && i < DEPTH) exp_q.push_back({vt[i].last, vt[i].data});
      @(negedge clk);
      chk("tbl_level", level,    vt[i].exp_level);
      chk("tbl_ne",    vled[13], vt[i].exp_ne);
      chk("tbl_ovf",   vled[14], vt[i].exp_ovf);
      chk("tbl_req",   vled[15], 0);
    end
    in_wr = 1'b0;

    // CLR_FLAGS pulse clears overflow after SYNC_STAGES+1 clocks.
    clr = 1'b1;
    @(negedge clk);
    chk("ovf_clr_early", vled[14], 1);
    repeat (2) @(negedge clk);
    chk("ovf_cleared", vled[14], 0);
    clr = 1'b0;

    // Only the first 16 bytes come out once EN is set.
    en = 1'b1;
    check_rx(16);

    // Basic single byte.
    push_one(8'hA5, 1'b1, 1'b1);
    check_rx(1);

    // Stream of ten bytes, seq wraps.
    for (int i = 0; i < 10; i++) begin
      in_wr = 1'b1; in_data = 8'(i); in_last = (i == 9);
      exp_q.push_back({(i == 9), 8'(i)});
      @(negedge clk);
    end
    in_wr = 1'b0;
    check_rx(10);

    // Randomized batches with random host response times.
    for (int b = 0; b < 6; b++) begin
      int n;
      ack_dly  = $urandom_range(0, 4);
      drop_dly = $urandom_range(0, 4);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        logic [7:0] d;
        logic       l;
        d = 8'($urandom); l = 1'($urandom);
        in_wr = 1'b1; in_data = d; in_last = l;
        exp_q.push_back({l, d});
        @(negedge clk);
      end
      in_wr = 1'b0;
      check_rx(n);
    end

    // EN dropped mid-handshake.
    ack_dly = 6; drop_dly = 3;
    for (int i = 0; i < 3; i++) begin
      in_wr = 1'b1; in_data = 8'hC0 + 8'(i); in_last = 1'b0;
      exp_q.push_back({1'b0, 8'hC0 + 8'(i)});
      @(negedge clk);
    end
    in_wr = 1'b0;
    g = 0;
    while (!vled[15] && g < 50) begin @(negedge clk); g++; end
    chk("en_drop_req_seen", vled[15], 1);
    en = 1'b0;
    g = 0;
    while ((rx_cnt < rx_rd + 1 || h_st != 0) && g < 200) begin @(negedge clk); g++; end
    chk("en_drop_first_done", rx_cnt, rx_rd + 1);
    any_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vled[15]) any_req = 1'b1;
    end
    chk("en_drop_no_req", any_req,  0);
    chk("en_drop_ne",     vled[13], 1);
    chk("en_drop_level",  level,    2);
    en = 1'b1;
    check_rx(3);

    // Timeout: host silent, flag rises after 100 cycles of REQ, late ACK completes.
    host_en = 1'b0; man_ack = 1'b0;
    push_one(8'h5A, 1'b0, 1'b1);
    g = 0;
    while (!vled[15] && g < 50) begin @(negedge clk); g++; end
    chk("tmo_req_seen", vled[15], 1);
    held = vled[8:0];
    for (int k = 2; k <= 105; k++) begin
      @(negedge clk);
      if (k == 95)  chk("tmo_early", vled[12], 0);
      if (k == 105) begin
        chk("tmo_set",       vled[12],  1);
        chk("tmo_req_held",  vled[15],  1);
        chk("tmo_data_held", vled[8:0], held);
        chk("tmo_data_exp",  held,      {exp_q[0].l, exp_q[0].d});
      end
    end
    man_ack = 1'b1;
    g = 0;
    while (vled[15] && g < 50) begin @(negedge clk); g++; end
    chk("tmo_late_ack_req", vled[15], 0);
    man_ack = 1'b0;
    void'(exp_q.pop_front());
    tot++;
    repeat (5) @(negedge clk);
    chk("tmo_seq_after", vled[11:9], tot % 8);
    chk("tmo_sticky",    vled[12],   1);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("tmo_cleared", vled[12], 0);
    clr = 1'b0;
    host_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a transfer with bytes still queued.
    ack_dly = 20;
    for (int i = 0; i < 4; i++) begin
      in_wr = 1'b1; in_data = 8'h90 + 8'(i); in_last = 1'b0;
      @(negedge clk);
    end
    in_wr = 1'b0;
    g = 0;
    while (!vled[15] && g < 50) begin @(negedge clk); g++; end
    chk("rst_req_seen", vled[15], 1);
    rst_n = 1'b0; host_rst = 1'b1;
    #1;
    chk("rst_mid_vled",  vled,  16'h0000);
    chk("rst_mid_level", level, 0);
    exp_q.delete(); tot = 0; rx_rd = 0;
    @(negedge clk);
    rst_n = 1'b1; host_rst = 1'b0; ack_dly = 5;
    any_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vled[15]) any_req = 1'b1;
    end
    chk("rst_no_req", any_req, 0);
    push_one(8'h3C, 1'b1, 1'b1);
    check_rx(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
